time_overlay_render: RTL
========================

// Module: time_overlay_render
// PURPOSE
// - Draws the current time (hh:mm:ss, 8 glyphs incl. colons) into the frame buffer from the 13-bit-wide character ROM.
// - Sits downstream of the photo-album controller/datapath: after a photo is copied to the frame buffer, the controller pulses start.
// - The controller hands IM_A/IM_D/IM_WEN to this block while busy=1.
// PARAMETERS
// FB_W      256  frame-buffer line pitch in pixels (IM_A = fb_base + y*FB_W + x)
// ORIGIN_X  8    x of top-left pixel of first glyph
// ORIGIN_Y  8    y of top-left pixel of first glyph
// CHAR_W    13   glyph width in pixels (= CR_Q width)
// CHAR_H    24   glyph rows; CR_A = {glyph[3:0], row[4:0]}
// FG_COLOR  24'hFFFFFF  RGB written for set glyph pixels
// PORTS
// clk       in   1   system clock, rising edge
// reset     in   1   asynchronous, active-low reset
// start     in   1   1-cycle request to render; ignored while busy
// time_bcd  in   24  {h1,h0,m1,m0,s1,s0}, BCD nibbles, sampled when start accepted
// fb_base   in   20  frame-buffer base address, sampled when start accepted
// CR_A      out  9   character ROM address
// CR_Q      in   13  ROM row data, valid 1 cycle after CR_A; bit 12 = leftmost pixel
// IM_A      out  20  image-memory address
// IM_D      out  24  image-memory write data
// IM_WEN    out  1   active-low write enable (0 = write this cycle)
// busy      out  1   high from cycle after start accept until done
// done      out  1   1-cycle pulse when last pixel slot has completed
// BEHAVIOUR
// - Reset values: CR_A=0, IM_A=0, IM_D=0, IM_WEN=1, busy=0, done=0, FSM=IDLE, all counters 0.
// - Glyph sequence g=0..7: h1,h0,COLON,m1,m0,COLON,s1,s0.
//   - COLON = glyph 10.
//   - A BCD nibble >9 renders glyph 11 (blank).
//   - Valid nibble n renders glyph n.
// - FSM states and transitions:
//   - IDLE: if start, latch time_bcd/fb_base, clear g/row, go FETCH.
//   - FETCH: 1 cycle. Drive CR_A={glyph(g),row}, go LATCH.
//   - LATCH: 1 cycle. Load CR_Q into 13-bit shift reg, col=0, go DRAW.
//   - DRAW: 13 cycles, one pixel slot each, col 0..12.
//     - Set bit: IM_WEN=0, IM_D=FG_COLOR.
//     - Clear bit: IM_WEN=1, no write; the slot is still consumed (fixed timing).
//     - IM_A = fb_base + (ORIGIN_Y+row)*FB_W + ORIGIN_X + g*CHAR_W + col.
//     - After col 12: next row -> FETCH. After row CHAR_H-1: next glyph -> FETCH. After glyph 7: go DONE.
//   - DONE: done=1 for 1 cycle, busy=0 in this cycle, go IDLE.
// - Timing: 15 cycles/row, 360/glyph, 2880 cycles from start-accept edge to done pulse (inclusive). Fixed, data-independent.
// - IM_A/IM_D/IM_WEN are registered and change only in DRAW. Outside DRAW: IM_WEN=1; IM_A and IM_D hold their last values.
// - Address arithmetic is 20-bit modulo 2^20; wrap is silent. No clipping against FB_W; the parent guarantees placement fits.
// - start while busy or in DONE: ignored, no queuing. start in IDLE on the same edge as DONE->IDLE is not possible (DONE precedes IDLE).
// - Changes on time_bcd/fb_base during busy have no effect.
// - reset asserted mid-render: immediately returns all outputs to reset values. The partially drawn overlay is left in memory.
// - IM_D is never read back; background pixels are untouched, giving a transparent overlay.
// STRUCTURE
// - Shared package ovl_pkg: state enum {IDLE,FETCH,LATCH,DRAW,DONE}, GLYPH_COLON=4'd10, GLYPH_BLANK=4'd11, glyph-sequence function.
// - Sub-module ovl_addr_gen: row-base accumulator.
//   - Adds FB_W per row rather than multiplying.
//   - Adds CHAR_W per glyph and +1 per column.
//   - Produces IM_A from these running offsets.
// - Top: FSM, counters (g 3b, row 5b, col 4b), shift register, output registers.
// TESTING
// 1. Reset: hold reset=0 -> IM_WEN=1, busy=0, done=0, CR_A=0, IM_A=0. Release -> stays IDLE with no start.
// 2. ROM model all ones, time_bcd=24'h123456, fb_base=0 -> exactly 8*24*13=2496 writes.
//    - First write at IM_A=8*256+8.
//    - Last write at (8+23)*256+8+7*13+12.
//    - done exactly 2880 cycles after start.
// 3. ROM glyph 1 row 0 = 13'h1000, other rows zero, time_bcd=24'h111111 -> only leftmost pixel of row 0 written for each '1' glyph (6 writes); colons per model.
// 4. time_bcd=24'hFA0000 -> glyphs 0,1 fetch CR_A upper nibble 11 (blank), never 15/10.
// 5. Second start pulse at cycle 100 of a render, and time_bcd changed mid-render -> ignored; output identical to undisturbed run.
// 6. reset=0 at cycle 1000 -> IM_WEN=1 next edge, busy=0. New start after release renders a full 2880-cycle pass.

Source files
------------

// File: rtl/ovl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ovl_pkg
// Description : Shared types and helpers for the time-overlay renderer.
//               Provides the FSM state encoding, special glyph codes and the
//               mapping from glyph slot to character-ROM glyph index.
// Revision    : 1.0 - initial release
// ============================================================================
package ovl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    DRAW  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] GLYPH_COLON = 4'd10;
  localparam logic [3:0] GLYPH_BLANK = 4'd11;
  localparam int         NUM_GLYPHS  = 8;

  // Slot order is h1,h0,:,m1,m0,:,s1,s0; an out-of-range BCD digit shows blank.
  function automatic logic [3:0] glyph_of(input logic [23:0] time_bcd,
                                          input logic [2:0]  g);
    logic [3:0] nib;
    logic       is_colon;
    is_colon = 1'b0;
    case (g)
      3'd0:    nib = time_bcd[23:20];
      3'd1:    nib = time_bcd[19:16];
      3'd3:    nib = time_bcd[15:12];
      3'd4:    nib = time_bcd[11:8];
      3'd6:    nib = time_bcd[7:4];
      3'd7:    nib = time_bcd[3:0];
      default: begin
        nib      = GLYPH_COLON;
        is_colon = 1'b1;
      end
    endcase
    if (!is_colon && (nib > 4'd9)) begin
      nib = GLYPH_BLANK;
    end
    return nib;
  endfunction

endpackage : ovl_pkg
`default_nettype wire

// File: rtl/ovl_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : ovl_addr_gen
// Description : Running frame-buffer address generator for the overlay.
//               Tracks the top-left of the current glyph and the start of the
//               current glyph row by accumulation, and steps the pixel address
//               by one per column slot. The pixel register drives IM_A.
// Revision    : 1.0 - initial release
// ============================================================================
module ovl_addr_gen #(
  parameter int FB_W     = 256,
  parameter int ORIGIN_X = 8,
  parameter int ORIGIN_Y = 8,
  parameter int CHAR_W   = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [19:0] i_base,
  input  logic        i_col_first,
  input  logic        i_col_step,
  input  logic        i_row_step,
  input  logic        i_glyph_step,
  output logic [19:0] o_pix_addr
);

  localparam logic [19:0] c_ORIGIN_OFS = 20'(ORIGIN_Y * FB_W + ORIGIN_X);
  localparam logic [19:0] c_ROW_STEP   = 20'(FB_W);
  localparam logic [19:0] c_GLYPH_STEP = 20'(CHAR_W);

  logic [19:0] r_glyph_top;
  logic [19:0] r_line;
  logic [19:0] r_pix;

  // Glyph-origin and row-start accumulators; a new glyph restarts at its top row
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_glyph_top <= '0;
      r_line      <= '0;
    end else if (i_load) begin
      r_glyph_top <= i_base + c_ORIGIN_OFS;
      r_line      <= i_base + c_ORIGIN_OFS;
    end else if (i_glyph_step) begin
      r_glyph_top <= r_glyph_top + c_GLYPH_STEP;
      r_line      <= r_glyph_top + c_GLYPH_STEP;
    end else if (i_row_step) begin
      r_line      <= r_line + c_ROW_STEP;
    end
  end

  // Pixel address: column 0 starts at the row start, later columns step by one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix <= '0;
    end else if (i_col_first) begin
      r_pix <= r_line;
    end else if (i_col_step) begin
      r_pix <= r_pix + 20'd1;
    end
  end

  assign o_pix_addr = r_pix;

endmodule : ovl_addr_gen
`default_nettype wire

// File: rtl/time_overlay_render.sv
`default_nettype none
// ============================================================================
// Module      : time_overlay_render
// Description : Renders hh:mm:ss (8 glyphs) from the character ROM into the
//               frame buffer with fixed, data-independent timing of 15 cycles
//               per glyph row. Set ROM bits are written in FG_COLOR; clear bits
//               skip the write so the background shows through.
// Revision    : 1.0 - initial release
// ============================================================================
module time_overlay_render
  import ovl_pkg::*;
#(
  parameter int          FB_W     = 256,
  parameter int          ORIGIN_X = 8,
  parameter int          ORIGIN_Y = 8,
  parameter int          CHAR_W   = 13,
  parameter int          CHAR_H   = 24,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [23:0]       time_bcd,
  input  logic [19:0]       fb_base,
  output logic [8:0]        CR_A,
  input  logic [CHAR_W-1:0] CR_Q,
  output logic [19:0]       IM_A,
  output logic [23:0]       IM_D,
  output logic              IM_WEN,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  state_t            w_next_state;
  logic [23:0]       r_time;
  logic [19:0]       r_base_unused_guard;
  logic [2:0]        r_g;
  logic [4:0]        r_row;
  logic [3:0]        r_col;
  logic [CHAR_W-1:0] r_shreg;

  logic              w_accept;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_last_glyph;
  logic              w_col_step;
  logic              w_row_step;
  logic              w_glyph_step;
  logic [8:0]        w_fetch_cra;

  assign w_accept     = (r_state == IDLE) && start;
  assign w_last_col   = (r_col == 4'(CHAR_W - 1));
  assign w_last_row   = (r_row == 5'(CHAR_H - 1));
  assign w_last_glyph = (r_g == 3'(NUM_GLYPHS - 1));
  assign w_col_step   = (r_state == DRAW) && !w_last_col;
  assign w_row_step   = (r_state == DRAW) && w_last_col && !w_last_row;
  assign w_glyph_step = (r_state == DRAW) && w_last_col && w_last_row && !w_last_glyph;

  // ROM address for the next fetch: first glyph row, next row, or next glyph
  assign w_fetch_cra = w_accept   ? {glyph_of(time_bcd, 3'd0), 5'd0} :
                       w_row_step ? {glyph_of(r_time, r_g), r_row + 5'd1} :
                                    {glyph_of(r_time, r_g + 3'd1), 5'd0};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one row is FETCH, LATCH, then CHAR_W DRAW slots
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = FETCH;
      FETCH:   w_next_state = LATCH;
      LATCH:   w_next_state = DRAW;
      DRAW: begin
        if (w_last_col) begin
          w_next_state = (w_last_row && w_last_glyph) ? DONE : FETCH;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Status outputs decoded from state; busy is already low in the DONE cycle
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      FETCH, LATCH, DRAW: busy = 1'b1;
      DONE:               done = 1'b1;
      default:            ;
    endcase
  end

  // Request capture, glyph/row/column counters and the row shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_time              <= '0;
      r_base_unused_guard <= '0;
      r_g                 <= '0;
      r_row               <= '0;
      r_col               <= '0;
      r_shreg             <= '0;
    end else begin
      if (w_accept) begin
        r_time <= time_bcd;
        r_g    <= '0;
        r_row  <= '0;
      end
      if (w_row_step) begin
        r_row <= r_row + 5'd1;
      end
      if (w_glyph_step) begin
        r_g   <= r_g + 3'd1;
        r_row <= '0;
      end
      if (r_state == LATCH) begin
        r_shreg <= CR_Q;
        r_col   <= '0;
      end else if (w_col_step) begin
        r_shreg <= r_shreg << 1;
        r_col   <= r_col + 4'd1;
      end
    end
  end

  // ROM address register, updated only when entering FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      CR_A <= '0;
    end else if (w_accept || w_row_step || w_glyph_step) begin
      CR_A <= w_fetch_cra;
    end
  end

  // Write strobe/data for the slot being entered; MSB of the row is leftmost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IM_WEN <= 1'b1;
      IM_D   <= '0;
    end else if (r_state == LATCH) begin
      IM_WEN <= ~CR_Q[CHAR_W-1];
      IM_D   <= FG_COLOR;
    end else if (w_col_step) begin
      IM_WEN <= ~r_shreg[CHAR_W-2];
    end else begin
      IM_WEN <= 1'b1;
    end
  end

  ovl_addr_gen #(
    .FB_W     (FB_W),
    .ORIGIN_X (ORIGIN_X),
    .ORIGIN_Y (ORIGIN_Y),
    .CHAR_W   (CHAR_W)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_accept),
    .i_base       (fb_base),
    .i_col_first  (r_state == LATCH),
    .i_col_step   (w_col_step),
    .i_row_step   (w_row_step),
    .i_glyph_step (w_glyph_step),
    .o_pix_addr   (IM_A)
  );

endmodule : time_overlay_render
`default_nettype wire
